// File: rtl/load_store_unit_if.sv
// Bundle of the request/response handshake and the data-memory bus of the load/store unit.
// master is the load/store unit's view; slave is the execute stage plus memory side.
interface load_store_unit_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;

   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;

   logic                  mem_read;
   logic                  mem_write;
   logic [DM_ADDRESS-1:0] mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [3:0]            mem_be;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata,
             mem_read, mem_write, mem_addr, mem_wdata, mem_be
   );

   modport slave (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata,
             mem_read, mem_write, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word request into one or two word-aligned memory
// cycles, with lane shifting for stores and extraction plus sign/zero extension for loads.
module load_store_unit #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   load_store_unit_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC0,
      S_CAP0,
      S_ACC1,
      S_CAP1,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic                  r_write;
   logic                  r_unsigned;
   logic [1:0]            r_size;
   logic [DM_ADDRESS-1:0] r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_lo;
   logic [DATA_W-1:0]     r_rdata;

   logic                  w_accept;
   logic [3:0]            w_mask;
   logic [1:0]            w_off;
   logic [7:0]            w_lanes;
   logic                  w_split;
   logic [63:0]           w_wshift;
   logic [DM_ADDRESS-3:0] w_word0;
   logic [DM_ADDRESS-3:0] w_word1;

   function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
      logic [31:0] s;
      logic [31:0] r;
      s = 32'(pair >> {off, 3'b000});
      case (size)
         2'b00:   r = {{24{s[7]  & ~uns}}, s[7:0]};
         2'b01:   r = {{16{s[15] & ~uns}}, s[15:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   assign w_accept = bus.req_valid && (r_state == S_IDLE);
   assign w_off    = r_addr[1:0];

   always_comb begin
      case (r_size)
         2'b00:   w_mask = 4'b0001;
         2'b01:   w_mask = 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   // Lanes spilling into the upper nibble belong to the following word, which is the split test.
   assign w_lanes  = {4'b0000, w_mask} << w_off;
   assign w_split  = |w_lanes[7:4];
   assign w_wshift = {32'b0, r_wdata} << {w_off, 3'b000};
   assign w_word0  = r_addr[DM_ADDRESS-1:2];
   assign w_word1  = w_word0 + {{(DM_ADDRESS-3){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_unsigned <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_lo       <= '0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_funct3[2];
            r_size     <= bus.req_funct3[1:0];
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
         end
         // The result register is loaded on the edge into DONE so it is valid with resp_valid.
         if (r_state == S_CAP0) begin
            r_lo <= bus.mem_rdata;
            if (!w_split)
               r_rdata <= extract({32'b0, bus.mem_rdata}, w_off, r_size, r_unsigned);
         end
         if (r_state == S_CAP1)
            r_rdata <= extract({bus.mem_rdata, r_lo}, w_off, r_size, r_unsigned);
      end
   end

   always_comb begin
      w_next         = r_state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_be     = 4'b0000;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               w_next = S_ACC0;
         end
         S_ACC0: begin
            bus.mem_addr = {w_word0, 2'b00};
            if (r_write) begin
               bus.mem_write = 1'b1;
               bus.mem_wdata = w_wshift[31:0];
               bus.mem_be    = w_lanes[3:0];
               w_next        = w_split ? S_ACC1 : S_DONE;
            end else begin
               bus.mem_read = 1'b1;
               w_next       = S_CAP0;
            end
         end
         S_CAP0: begin
            w_next = w_split ? S_ACC1 : S_DONE;
         end
         S_ACC1: begin
            bus.mem_addr = {w_word1, 2'b00};
            if (r_write) begin
               bus.mem_write = 1'b1;
               bus.mem_wdata = w_wshift[63:32];
               bus.mem_be    = w_lanes[7:4];
               w_next        = S_DONE;
            end else begin
               bus.mem_read = 1'b1;
               w_next       = S_CAP1;
            end
         end
         S_CAP1: begin
            w_next = S_DONE;
         end
         S_DONE: begin
            bus.resp_valid = 1'b1;
            w_next         = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign bus.resp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed reference model and a queue of
// expected memory cycles checked whenever the unit strobes the memory.
module tb_load_store_unit;

   typedef struct {
      logic        wr;
      logic [8:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } cyc_t;

   logic        clk;
   logic        reset_n;
   int          checks;
   int          errors;
   logic [31:0] last_rd;
   cyc_t        exp_q[$];
   logic [7:0]  rmem[512];
   logic [31:0] dmem[128];

   load_store_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

   load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Word-organised memory; read data appears the cycle after mem_read.
   always @(posedge clk) begin
      logic [31:0] w;
      if (bus.mem_read)
         bus.mem_rdata <= dmem[bus.mem_addr[8:2]];
      if (bus.mem_write) begin
         w = dmem[bus.mem_addr[8:2]];
         for (int i = 0; i < 4; i++)
            if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
         dmem[bus.mem_addr[8:2]] <= w;
      end
   end

   always @(negedge clk) begin
      cyc_t c;
      check("strobe_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (!bus.mem_write) check("be_idle_zero", 32'(bus.mem_be), 32'd0);
      if (bus.mem_read || bus.mem_write) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_cycle: observed read=%b write=%b addr=%h, expected no cycle",
                   bus.mem_read, bus.mem_write, bus.mem_addr);
         end
         if (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            check("cyc_write", 32'(bus.mem_write), 32'(c.wr));
            check("cyc_addr", 32'(bus.mem_addr), 32'(c.addr));
            check("cyc_be", 32'(bus.mem_be), 32'(c.be));
            if (c.wr) check("cyc_wdata", bus.mem_wdata, c.wdata);
         end
      end
   end

   // Byte-by-byte model of one access: queues the expected memory cycles and updates rmem.
   task automatic push_cycles(input logic wr, input logic [2:0] f3, input logic [8:0] a,
                              input logic [31:0] wd, output bit split);
      cyc_t c0, c1;
      int nb;
      logic [8:0] ba;
      nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      c0.wr = wr; c0.addr = {a[8:2], 2'b00}; c0.be = 4'b0000; c0.wdata = '0;
      c1 = c0;
      c1.addr = c0.addr + 9'd4;
      split = 1'b0;
      for (int i = 0; i < nb; i++) begin
         ba = a + 9'(i);
         if (wr) rmem[ba] = wd[8*i +: 8];
         if (ba[8:2] == c0.addr[8:2]) begin
            if (wr) begin
               c0.be[ba[1:0]] = 1'b1;
               c0.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
            end
         end else begin
            split = 1'b1;
            if (wr) begin
               c1.be[ba[1:0]] = 1'b1;
               c1.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
            end
         end
      end
      exp_q.push_back(c0);
      if (split) exp_q.push_back(c1);
   endtask

   function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f3);
      logic [31:0] v;
      int nb;
      nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rmem[a + 9'(i)];
      if (nb == 1 && !f3[2] && v[7])  v[31:8]  = '1;
      if (nb == 2 && !f3[2] && v[15]) v[31:16] = '1;
      return v;
   endfunction

   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
      bit split;
      int lat;
      push_cycles(wr, f3, a, wd, split);
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_write  = ~wr;
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = 9'($urandom);
      bus.req_wdata  = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.resp_valid && lat < 12);
      check("resp_latency", 32'(lat), wr ? (split ? 32'd3 : 32'd2) : (split ? 32'd5 : 32'd3));
      if (wr) begin
         check("rdata_hold", bus.resp_rdata, last_rd);
      end else begin
         check("load_rdata", bus.resp_rdata, exp_rd);
         last_rd = exp_rd;
      end
   endtask

   initial begin
      bit          split;
      int          lat;
      int          seen;
      cyc_t        c;
      logic [8:0]  a;
      logic [2:0]  f3;
      logic [31:0] wd;

      checks  = 0;
      errors  = 0;
      last_rd = '0;
      for (int i = 0; i < 512; i++) rmem[i] = 8'h00;
      for (int i = 0; i < 128; i++) dmem[i] = 32'h0;
      bus.mem_rdata  = '0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      reset_n        = 1'b0;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_mem_read", 32'(bus.mem_read), 32'd0);
      check("rst_mem_write", 32'(bus.mem_write), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_be", 32'(bus.mem_be), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      do_req(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, '0);
      do_req(1'b0, 3'b010, 9'h010, '0, 32'hDEADBEEF);
      do_req(1'b1, 3'b000, 9'h013, 32'h000000A5, '0);
      do_req(1'b0, 3'b000, 9'h013, '0, 32'hFFFFFFA5);
      do_req(1'b0, 3'b100, 9'h013, '0, 32'h000000A5);
      do_req(1'b1, 3'b001, 9'h023, 32'h00001234, '0);
      do_req(1'b0, 3'b101, 9'h023, '0, 32'h00001234);
      do_req(1'b0, 3'b001, 9'h023, '0, 32'h00001234);
      do_req(1'b1, 3'b010, 9'h1FE, 32'h11223344, '0);
      do_req(1'b0, 3'b010, 9'h1FE, '0, 32'h11223344);
      do_req(1'b1, 3'b010, 9'h040, 32'h80000001, '0);
      do_req(1'b0, 3'b011, 9'h040, '0, 32'h80000001);

      // req_valid held through DONE: busy while in flight, re-accepted only after DONE.
      push_cycles(1'b1, 3'b010, 9'h080, 32'hCAFEF00D, split);
      push_cycles(1'b1, 3'b010, 9'h080, 32'hCAFEF00D, split);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 9'h080;
      bus.req_wdata  = 32'hCAFEF00D;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.resp_valid) check("ready_busy", 32'(bus.req_ready), 32'd0);
      end while (!bus.resp_valid && lat < 12);
      check("held_latency", 32'(lat), 32'd2);
      check("ready_in_done", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("ready_after_done", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      check("reaccept_strobe", 32'(bus.mem_write), 32'd1);
      lat = 1;
      while (!bus.resp_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check("held_second_latency", 32'(lat), 32'd2);
      bus.req_valid = 1'b0;

      for (int k = 0; k < 8; k++) begin
         a  = 9'($urandom);
         f3 = {1'b0, 2'($urandom)};
         wd = $urandom;
         if (f3[1:0] == 2'b00) wd = wd & 32'h000000FF;
         if (f3[1:0] == 2'b01) wd = wd & 32'h0000FFFF;
         do_req(1'b1, f3, a, wd, '0);
         f3[2] = 1'($urandom);
         do_req(1'b0, f3, a, '0, model_load(a, f3));
      end

      // Reset during CAP0 of a split load: only the first read may ever appear.
      c.wr = 1'b0; c.addr = 9'h1FC; c.be = 4'b0000; c.wdata = '0;
      exp_q.push_back(c);
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 9'h1FE;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_mem_read", 32'(bus.mem_read), 32'd0);
      check("abort_mem_write", 32'(bus.mem_write), 32'd0);
      check("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("abort_resp_rdata", bus.resp_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.resp_valid) seen++;
      end
      check("no_resp_after_abort", 32'(seen), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
